// File: rtl/mem_stall_req_pkg.sv
// Shared types and constants for the memory-stage access requester.
// State encodings and stall/reset levels are defined here only.
package mem_stall_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic StallYes   = 1'b1;
  localparam logic StallNo    = 1'b0;
  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } bus_req_t;

endpackage

// File: rtl/mem_stall_req_if.sv
// MEM-stage request/stall signals plus the external data bus.
// master = requester (drives bus_*), slave = pipeline/bus environment.
interface mem_stall_req_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        stall_mem;
  logic        stallreq_mem;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel, stall_mem,
    input  bus_ack, bus_rdata,
    output stallreq_mem, mem_rdata, mem_err,
    output bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel
  );

  modport slave (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel, stall_mem,
    output bus_ack, bus_rdata,
    input  stallreq_mem, mem_rdata, mem_err,
    input  bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel
  );
endinterface

// File: rtl/mem_wait_cnt.sv
// Wait-state counter and completion compare for one bus access.
// Optional ACCESS timeout counter enabled by MEM_TIMEOUT_EN.
module mem_wait_cnt
  import mem_stall_req_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic wait_done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Saturates so a slow ack still sees wait_done held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)                 cnt <= '0;
    else if (start)                       cnt <= '0;
    else if (run && (cnt != WAIT_LIM))    cnt <= cnt + 1'b1;
  end

  assign wait_done = (cnt == WAIT_LIM);

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)                 tcnt <= '0;
    else if (start)                       tcnt <= '0;
    else if (run && (tcnt != TO_LIM))     tcnt <= tcnt + 1'b1;
  end

  // Fires during the TIMEOUT-th ACCESS cycle.
  assign timeout = run && (tcnt == TO_LIM);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/mem_stall_req.sv
// MEM-stage bus requester: runs a wait-stated bus access and stalls the pipe
// until data is captured. Define MEM_TIMEOUT_EN to enable the ACCESS abort.
module mem_stall_req
  import mem_stall_req_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_stall_req_if.master  m
);

  state_e   state, state_nxt;
  bus_req_t req_q;
  logic        cyc_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        wait_done, timeout;
  logic        start, complete, abort;

  assign start    = (state == ST_IDLE) && m.mem_req;
  assign complete = (state == ST_ACCESS) && m.bus_ack && wait_done;
  assign abort    = (state == ST_ACCESS) && timeout && !complete;

  mem_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .run       (state == ST_ACCESS),
    .wait_done (wait_done),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (m.mem_req)              state_nxt = ST_ACCESS;
      ST_ACCESS: if (complete || abort)      state_nxt = ST_DONE;
      ST_DONE:   if (!m.stall_mem)           state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      req_q   <= '0;
      cyc_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (m.mem_req) begin
          req_q <= '{we: m.mem_we, addr: m.mem_addr, wdata: m.mem_wdata, sel: m.mem_sel};
          cyc_q <= 1'b1;
          err_q <= 1'b0;
        end
        ST_ACCESS: begin
          if (complete) begin
            cyc_q <= 1'b0;
            if (!req_q.we) rdata_q <= m.bus_rdata;
          end else if (abort) begin
            cyc_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ST_DONE: if (!m.stall_mem) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Combinational so the request cycle itself stalls; masked during reset.
  assign m.stallreq_mem = (rst == RstEnable) ? StallNo :
                          (start || (state == ST_ACCESS)) ? StallYes : StallNo;

  assign m.mem_rdata = rdata_q;
  assign m.mem_err   = err_q;
  assign m.bus_cyc   = cyc_q;
  assign m.bus_we    = req_q.we;
  assign m.bus_addr  = req_q.addr;
  assign m.bus_wdata = req_q.wdata;
  assign m.bus_sel   = req_q.sel;

endmodule

// File: tb/tb_mem_stall_req.sv
// Self-checking bench for mem_stall_req: transaction-level model plus
// directed literal checks and randomized traffic.
module tb_mem_stall_req;
  localparam int W  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stall_req_if bif();

  mem_stall_req #(.WAIT_CYCLES(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .m   (bif)
  );

  int nvec = 0;
  int nerr = 0;

  // model: one access = request cycle, ACCESS cycles counted by age, DONE hold
  bit          m_active, m_done, m_err;
  int          m_age;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_sel;

  logic        s_stall, s_cyc, s_err;
  logic [31:0] s_rdata, s_wdata;
  logic [3:0]  s_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_age = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_sel = 0;
  endtask

  task automatic model_next();
    bit fin, tmo;
    if (rst) begin
      model_reset();
    end else if (m_done) begin
      if (!bif.stall_mem) begin m_done = 0; m_err = 0; end
    end else if (m_active) begin
      fin = bif.bus_ack && (m_age - 1 >= W);
`ifdef MEM_TIMEOUT_EN
      tmo = !fin && (m_age >= TO);
`else
      tmo = 0;
`endif
      if (fin) begin
        m_active = 0; m_done = 1;
        if (!m_we) m_rdata = bif.bus_rdata;
      end else if (tmo) begin
        m_active = 0; m_done = 1; m_rdata = 0; m_err = 1;
      end
      m_age++;
    end else if (bif.mem_req) begin
      m_active = 1; m_age = 1; m_err = 0;
      m_we = bif.mem_we; m_addr = bif.mem_addr; m_wdata = bif.mem_wdata; m_sel = bif.mem_sel;
    end
  endtask

  // One clock: compare at negedge, advance model, then move past the edge.
  task automatic cycle();
    bit exp_stall;
    @(negedge clk);
    s_stall = bif.stallreq_mem; s_cyc = bif.bus_cyc; s_err = bif.mem_err;
    s_rdata = bif.mem_rdata; s_wdata = bif.bus_wdata; s_sel = bif.bus_sel;
    exp_stall = !rst && (m_active || (!m_done && bif.mem_req));
    chk("stallreq_mem", {31'd0, s_stall}, {31'd0, exp_stall});
    chk("bus_cyc", {31'd0, s_cyc}, {31'd0, m_active});
    chk("mem_rdata", s_rdata, m_rdata);
    chk("mem_err", {31'd0, s_err}, {31'd0, m_err});
    chk("bus_we", {31'd0, bif.bus_we}, {31'd0, m_we});
    chk("bus_addr", bif.bus_addr, m_addr);
    chk("bus_wdata", s_wdata, m_wdata);
    chk("bus_sel", {28'd0, s_sel}, {28'd0, m_sel});
    model_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    model_reset();
    bif.mem_req = 1; bif.mem_we = 0; bif.mem_addr = 32'h100; bif.mem_wdata = 0;
    bif.mem_sel = 4'hF; bif.stall_mem = 0; bif.bus_ack = 0; bif.bus_rdata = 0;

    // reset held with a pending request
    cycle();
    chk("rst_stall_lit", {31'd0, s_stall}, 32'd0);
    chk("rst_cyc_lit", {31'd0, s_cyc}, 32'd0);
    chk("rst_rdata_lit", s_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // load, ack held high: 4 stall cycles then DONE with data
    bif.bus_ack = 1; bif.bus_rdata = 32'hDEADBEEF;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!s_stall) break;
      n++;
    end
    chk("load_stall_cycles", n, W + 2);
    chk("load_rdata_lit", s_rdata, 32'hDEADBEEF);
    bif.mem_req = 0; bif.bus_ack = 0;
    cycle();

    // store with an early ack that must be ignored
    bif.mem_req = 1; bif.mem_we = 1; bif.mem_wdata = 32'h12345678; bif.mem_sel = 4'b0011;
    cycle();
    bif.bus_ack = 1;
    cycle();
    bif.bus_ack = 0;
    for (int i = 2; i <= 5; i++) begin
      if (i == 5) bif.bus_ack = 1;
      cycle();
      chk("store_stall_lit", {31'd0, s_stall}, 32'd1);
      chk("store_wdata_lit", s_wdata, 32'h12345678);
      chk("store_sel_lit", {28'd0, s_sel}, 32'h3);
    end
    bif.bus_ack = 0; bif.mem_req = 0;
    cycle();
    chk("store_done_stall_lit", {31'd0, s_stall}, 32'd0);
    chk("store_keeps_rdata_lit", s_rdata, 32'hDEADBEEF);

    // external hold in DONE with mem_req asserted
    bif.mem_req = 1; bif.mem_we = 0; bif.mem_addr = 32'h200; bif.bus_ack = 1;
    bif.bus_rdata = 32'hCAFEF00D;
    repeat (W + 2) cycle();
    bif.stall_mem = 1; bif.mem_addr = 32'h300;
    repeat (3) begin
      cycle();
      chk("hold_cyc_lit", {31'd0, s_cyc}, 32'd0);
      chk("hold_stall_lit", {31'd0, s_stall}, 32'd0);
      chk("hold_rdata_lit", s_rdata, 32'hCAFEF00D);
    end
    bif.stall_mem = 0; bif.mem_req = 0;
    cycle();
    cycle();
    chk("hold_idle_cyc_lit", {31'd0, s_cyc}, 32'd0);

    // asynchronous reset mid-ACCESS
    bif.mem_req = 1; bif.bus_ack = 0;
    cycle();
    cycle();
    chk("mid_cyc_before_lit", {31'd0, s_cyc}, 32'd1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_cyc_lit", {31'd0, bif.bus_cyc}, 32'd0);
    chk("mid_rst_stall_lit", {31'd0, bif.stallreq_mem}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0; bif.mem_req = 0;
    cycle();

`ifdef MEM_TIMEOUT_EN
    // timeout: ack never comes
    bif.mem_req = 1; bif.bus_ack = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      bif.mem_req = 0;
      if (!s_stall) break;
      n++;
    end
    chk("tmo_stall_cycles", n, TO + 1);
    chk("tmo_err_lit", {31'd0, s_err}, 32'd1);
    chk("tmo_rdata_lit", s_rdata, 32'd0);
    bif.bus_ack = 1;
    cycle();
    chk("tmo_err_clear_lit", {31'd0, s_err}, 32'd0);
    bif.bus_ack = 0;
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1; model_reset();
        cycle();
        rst = 0;
      end else begin
        bif.mem_req   = ($urandom_range(1) == 1);
        bif.mem_we    = ($urandom_range(1) == 1);
        bif.mem_addr  = $urandom;
        bif.mem_wdata = $urandom;
        bif.mem_sel   = 4'($urandom_range(15));
        bif.stall_mem = ($urandom_range(9) < 3);
        bif.bus_ack   = ($urandom_range(9) < 4);
        bif.bus_rdata = $urandom;
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_stall_req.md
# mem_stall_req

Memory-stage access requester. Sits between the MEM pipeline stage and the external data bus, and produces `stallreq_mem` for the stall controller. When the MEM stage presents a load or store, the block runs a multi-cycle bus transaction with wait states and an acknowledge. It holds `stallreq_mem` until the data is captured, then releases the pipeline for exactly one advancing edge per access.

## Interface
- `WAIT_CYCLES`, default 2: minimum wait states per access; range 0..15.
- `TIMEOUT`, default 64: cycles in ACCESS before abort; used only with `MEM_TIMEOUT_EN`.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high (`RstEnable` = 1).
- `mem_req`  in  1  MEM stage holds a load/store this cycle.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  store data.
- `mem_sel`  in  4  byte enables.
- `stall_mem`  in  1  from stall controller; 1 = MEM stage frozen this cycle.
- `stallreq_mem`  out  1  stall request to the stall controller (`StallYes` = 1).
- `mem_rdata`  out  32  load data, registered, valid in DONE.
- `mem_err`  out  1  access aborted by timeout.
- `bus_cyc`  out  1  bus transaction active.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_sel`  out  1/32/32/4  latched request.
- `bus_ack`  in  1  target completion.
- `bus_rdata`  in  32  target read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE.** When `mem_req`=1:
  - latch we/addr/wdata/sel into the `bus_*` registers, set `bus_cyc`=1, clear the wait counter, go to ACCESS.
  - `stallreq_mem` is combinational: `(IDLE & mem_req) | ACCESS`. The request cycle therefore stalls immediately.
- **ACCESS.**
  - Wait counter increments each cycle and saturates at `WAIT_CYCLES`.
  - Completion condition: `bus_ack`=1 and counter == `WAIT_CYCLES`. An earlier `bus_ack` is ignored.
  - On completion: `bus_cyc`←0. For a load, `mem_rdata`←`bus_rdata`. For a store, `mem_rdata` is unchanged. Go to DONE.
- **DONE.**
  - `stallreq_mem`=0. The pipeline advances on the next edge, carrying `mem_rdata`.
  - Exit to IDLE when `stall_mem`=0. If `stall_mem`=1 (external hold), stay in DONE with no new bus cycle.
  - `mem_req` is ignored in DONE, so the same instruction is never re-issued.
- Reset values (asynchronous, any state, including mid-ACCESS):
  - state=IDLE; `bus_cyc`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_sel`, `mem_rdata`, `mem_err` = 0; counters = 0.
  - `stallreq_mem` is forced 0 while `rst`=1.
  - An in-flight bus cycle is abandoned without waiting for ack.
- Wait counter is 4 bits wide.

## Timing
- Total latency with `bus_ack` held high: `stallreq_mem` is high for `WAIT_CYCLES`+2 cycles, then one DONE cycle.
  - Cycle 0: IDLE request.
  - Cycles 1..`WAIT_CYCLES`+1: ACCESS.
  - Cycle `WAIT_CYCLES`+2: DONE.
- Each extra cycle of late `bus_ack` adds one stall cycle.
- `bus_*` outputs are registered and stable for the whole of ACCESS.
- Back-to-back accesses: the next access is accepted in the cycle after DONE. There is a minimum of one non-stalled cycle between accesses.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A saturating timeout counter runs in ACCESS.
  - At `TIMEOUT` cycles without completion: drop `bus_cyc`, set `mem_rdata`=0, go to DONE, and assert `mem_err`=1 for that DONE stay only.
  - A late `bus_ack` after the abort is ignored.
- **`MEM_TIMEOUT_EN` undefined:**
  - ACCESS waits indefinitely.
  - `mem_err` is tied 0.
  - `TIMEOUT` is unused.

## Structure
- FSM state encodings, `StallYes`/`StallNo` and `RstEnable`/`RstDisable` live in the shared defines header. Do not redefine them locally.
- One sub-module, `mem_wait_cnt`, holds the wait counter, the completion compare and (under the macro) the timeout counter. Its outputs are `wait_done` and `timeout`.

## Test plan
- **Reset.** `rst`=1 with `mem_req`=1 → `stallreq_mem`=0, `bus_cyc`=0, `mem_rdata`=0. Release reset → the access starts in the next cycle.
- **Load, `WAIT_CYCLES`=2, ack held 1.** Load at addr 0x100, `bus_rdata`=0xDEADBEEF → `stallreq_mem`=1 for 4 cycles, then DONE with `mem_rdata`=0xDEADBEEF and `stallreq_mem`=0.
- **Store with early ack.** Store 0x12345678, sel=4'b0011, `bus_ack` pulsed only in the first ACCESS cycle and again at cycle 5 → the first ack is ignored. Completion is at cycle 5, and `bus_wdata`/`bus_sel` are stable throughout.
- **External hold in DONE.** `stall_mem`=1 held for 3 cycles in DONE → the block stays in DONE with no new `bus_cyc` despite `mem_req`=1. It returns to IDLE the cycle after `stall_mem`=0.
- **Reset mid-operation.** `rst` asserted during ACCESS → `bus_cyc` and `stallreq_mem` drop asynchronously, before the next edge.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT`=8).** `bus_ack` is never asserted → abort after 8 ACCESS cycles, one DONE cycle with `mem_err`=1 and `mem_rdata`=0.
